constraint_sample_ctrl: RTL

CONSTRAINT_SAMPLE_CTRL -- requirements
Module: constraint_sample_ctrl

---
 rtl/sampler_pkg.sv | 16 +
 rtl/constraint_sample_ctrl_if.sv | 8 +
 rtl/sampler_lfsr32.sv | 16 +
 rtl/constraint_sample_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// sampler_pkg: shared FSM states, LFSR constants and lane helpers for the constraint sampler
package sampler_pkg;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003;
  localparam logic [LFSR_W-1:0] LANE_K = 32'h9E3779B9;
  typedef enum logic [2:0] {IDLE, GEN, CHECK, OUT, DONE} state_t;
  function automatic logic [LFSR_W-1:0] galois_step(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
  endfunction
  // An all-zero Galois state would lock up, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] seed, input int unsigned i);
    logic [LFSR_W-1:0] v;
    v = seed ^ (LFSR_W'(i) * LANE_K);
    return (v == '0) ? LFSR_W'(1) : v;
  endfunction
endpackage

// File: rtl/constraint_sample_ctrl_if.sv
// constraint_sample_ctrl_if: accepted-sample valid/ready/data handshake
interface constraint_sample_ctrl_if #(parameter int CAND_W = 512);
  logic sample_valid_o;
  logic sample_ready_i;
  logic [CAND_W-1:0] sample_data_o;
  modport master(output sample_valid_o, output sample_data_o, input sample_ready_i);
  modport slave(input sample_valid_o, input sample_data_o, output sample_ready_i);
endinterface

// File: rtl/sampler_lfsr32.sv
// sampler_lfsr32: one 32-bit Galois LFSR lane with synchronous load and step
module sampler_lfsr32
  import sampler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= LFSR_W'(1);
    else if (load) q <= load_val;
    else if (step) q <= galois_step(q);
endmodule

// File: rtl/constraint_sample_ctrl.sv
// constraint_sample_ctrl: LFSR candidate generator that retries until an external checker accepts.
// Define SAMPLER_STATS_EN to enable the total_tries_o/accepted_o run statistics.
module constraint_sample_ctrl
  import sampler_pkg::*;
#(
  parameter int CAND_W    = 512,
  parameter int NUM_LANES = CAND_W / 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [31:0]               seed_i,
  input  logic [15:0]               num_samples_i,
  input  logic [15:0]               max_tries_i,
  output logic [CAND_W-1:0]         cand_o,
  input  logic                      sat_i,
  constraint_sample_ctrl_if.master  smp,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      fail_o,
  output logic [15:0]               tries_o,
  output logic [31:0]               total_tries_o,
  output logic [15:0]               accepted_o
);
  state_t state, state_n;
  logic accept;
  logic [15:0] num_q, max_q, acc_q, tries_n;
  logic [CAND_W-1:0] lane_nxt;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LFSR_W-1:0] q;
    sampler_lfsr32 u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .step    (state == GEN),
      .load_val(lane_seed(seed_i, i)),
      .q       (q)
    );
    assign lane_nxt[i*LFSR_W +: LFSR_W] = galois_step(q);
  end
  always_comb begin
    state_n = state;
    accept = 1'b0;
    tries_n = (tries_o == 16'hFFFF) ? tries_o : tries_o + 16'd1;
    case (state)
      IDLE: begin
        accept = start_i;
        state_n = !start_i ? IDLE : (num_samples_i != 16'd0) ? GEN : DONE;
      end
      GEN: state_n = CHECK;
      CHECK: state_n = sat_i ? OUT : (max_q != 16'd0 && tries_n == max_q) ? DONE : GEN;
      OUT: state_n = !smp.sample_ready_i ? OUT : (acc_q + 16'd1 == num_q) ? DONE : GEN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cand_o <= '0;
      smp.sample_data_o <= '0;
      num_q <= '0;
      max_q <= '0;
      acc_q <= '0;
      tries_o <= '0;
      fail_o <= 1'b0;
    end else begin
      if (accept) begin
        num_q <= num_samples_i;
        max_q <= max_tries_i;
        acc_q <= '0;
        tries_o <= '0;
        fail_o <= 1'b0;
      end
      if (state == GEN) cand_o <= lane_nxt;
      if (state == CHECK && sat_i) smp.sample_data_o <= cand_o;
      if (state == CHECK && !sat_i) begin
        tries_o <= tries_n;
        fail_o <= (state_n == DONE);
      end
      if (state == OUT && smp.sample_ready_i) begin
        acc_q <= acc_q + 16'd1;
        tries_o <= '0;
      end
    end
  assign smp.sample_valid_o = (state == OUT);
  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);
`ifdef SAMPLER_STATS_EN
  logic [31:0] tot_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tot_q <= '0;
    else if (accept) tot_q <= '0;
    else if (state == CHECK && tot_q != '1) tot_q <= tot_q + 32'd1;
  assign total_tries_o = tot_q;
  assign accepted_o = acc_q;
`else
  assign total_tries_o = '0;
  assign accepted_o = '0;
`endif
endmodule
